// File: rtl/cotm_pkg.sv
// cotm_pkg: shared types and constants for the CoTM clause vote path.
// States, default sizes and the class-sum width derivation.
package cotm_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        ACCUM  = 3'd1,
        SUM    = 3'd2,
        ARGMAX = 3'd3,
        DONE   = 3'd4,
        CLAMP  = 3'd5
    } cva_state_e;

    localparam int NUM_CLAUSES_DEF = 16;
    localparam int NUM_CLASSES_DEF = 10;
    localparam int WEIGHT_W_DEF    = 8;
    localparam int CLAMP_T_DEF     = 64;

    function automatic int sum_width(input int weight_w, input int num_clauses);
        return weight_w + $clog2(num_clauses) + 1;
    endfunction

endpackage

// File: rtl/clause_vote_accumulator_if.sv
// clause_vote_accumulator_if: clause stream, weight port and result handshake.
// master drives clauses/weights/out_ready; slave is the accumulator.
interface clause_vote_accumulator_if
    import cotm_pkg::*;
#(
    parameter int NUM_CLAUSES = NUM_CLAUSES_DEF,
    parameter int NUM_CLASSES = NUM_CLASSES_DEF,
    parameter int WEIGHT_W    = WEIGHT_W_DEF,
    parameter int SUM_W       = sum_width(WEIGHT_W, NUM_CLAUSES)
);
    localparam int CLS_W = $clog2(NUM_CLASSES);
    localparam int CLA_W = $clog2(NUM_CLAUSES);

    logic                         frame_start;
    logic                         clause_valid;
    logic [NUM_CLAUSES-1:0]       clause_op;
    logic                         frame_end;
    logic                         w_we;
    logic [CLS_W-1:0]             w_class;
    logic [CLA_W-1:0]             w_clause;
    logic [WEIGHT_W-1:0]          w_data;
    logic                         w_err;
    logic                         busy;
    logic                         out_valid;
    logic                         out_ready;
    logic [CLS_W-1:0]             pred_class;
    logic [NUM_CLASSES*SUM_W-1:0] class_sums;

    modport master (
        output frame_start, clause_valid, clause_op, frame_end,
        output w_we, w_class, w_clause, w_data, out_ready,
        input  w_err, busy, out_valid, pred_class, class_sums
    );

    modport slave (
        input  frame_start, clause_valid, clause_op, frame_end,
        input  w_we, w_class, w_clause, w_data, out_ready,
        output w_err, busy, out_valid, pred_class, class_sums
    );

endinterface

// File: rtl/class_argmax_seq.sv
// class_argmax_seq: one class per cycle argmax, lowest index wins ties.
// start marks the class-0 cycle; done marks the last class cycle.
module class_argmax_seq #(
    parameter int NUM_CLASSES = 10,
    parameter int SUM_W       = 13
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           start,
    input  logic signed [SUM_W-1:0]        sums [NUM_CLASSES],
    output logic                           done,
    output logic [$clog2(NUM_CLASSES)-1:0] pred
);
    localparam int CW = $clog2(NUM_CLASSES);
    localparam logic [CW-1:0] LAST = CW'(NUM_CLASSES - 1);

    logic                    run;
    logic [CW-1:0]           k;
    logic [CW-1:0]           best_idx;
    logic signed [SUM_W-1:0] best;
    logic [CW-1:0]           cur_k;
    logic signed [SUM_W-1:0] cur;
    logic                    take;

    // Candidate for this cycle; strict > keeps the earlier index on ties.
    always_comb begin
        cur_k = start ? '0 : k;
        cur   = sums[cur_k];
        take  = start || (cur > best);
        done  = run && (k == LAST);
        pred  = take ? cur_k : best_idx;
    end

    // Running best and class counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            run      <= 1'b0;
            k        <= '0;
            best     <= '0;
            best_idx <= '0;
        end else if (start) begin
            run      <= 1'b1;
            k        <= CW'(1);
            best     <= cur;
            best_idx <= '0;
        end else if (run) begin
            if (take) begin
                best     <= cur;
                best_idx <= k;
            end
            if (done) begin
                run <= 1'b0;
                k   <= '0;
            end else begin
                k <= k + 1'b1;
            end
        end
    end

endmodule

// File: rtl/clause_vote_accumulator.sv
// clause_vote_accumulator: ORs clause hits per frame, weighted class sums, argmax.
// Optional macro CLASS_SUM_CLAMP_EN adds a saturate-to-CLAMP_T stage before argmax.
module clause_vote_accumulator
    import cotm_pkg::*;
#(
    parameter int NUM_CLAUSES = NUM_CLAUSES_DEF,
    parameter int NUM_CLASSES = NUM_CLASSES_DEF,
    parameter int WEIGHT_W    = WEIGHT_W_DEF,
    parameter int SUM_W       = sum_width(WEIGHT_W, NUM_CLAUSES)
`ifdef CLASS_SUM_CLAMP_EN
    , parameter int CLAMP_T   = CLAMP_T_DEF
`endif
) (
    input  logic                     clk,
    input  logic                     rst,
    clause_vote_accumulator_if.slave bus
);
    localparam int CLS_W = $clog2(NUM_CLASSES);
    localparam int CLA_W = $clog2(NUM_CLAUSES);

    localparam logic [2:0] S_IDLE   = IDLE;
    localparam logic [2:0] S_ACCUM  = ACCUM;
    localparam logic [2:0] S_SUM    = SUM;
    localparam logic [2:0] S_ARGMAX = ARGMAX;
    localparam logic [2:0] S_DONE   = DONE;
`ifdef CLASS_SUM_CLAMP_EN
    localparam logic [2:0] S_CLAMP  = CLAMP;
    localparam logic signed [SUM_W-1:0] C_HI = SUM_W'(CLAMP_T);
    localparam logic signed [SUM_W-1:0] C_LO = -C_HI;
`endif
    localparam logic [CLA_W-1:0] LAST_IDX = CLA_W'(NUM_CLAUSES - 1);

    logic [2:0]                 state;
    logic [NUM_CLAUSES-1:0]     fired;
    logic [CLA_W-1:0]           idx;
    logic signed [WEIGHT_W-1:0] w_mem [NUM_CLASSES][NUM_CLAUSES];
    logic signed [SUM_W-1:0]    sum   [NUM_CLASSES];
    logic signed [SUM_W-1:0]    w_ext [NUM_CLASSES];
    logic                       am_start;
    logic                       am_done;
    logic [CLS_W-1:0]           am_pred;
    logic [CLS_W-1:0]           pred_q;
    logic                       out_valid_q;
    logic                       w_err_q;
    logic                       w_ok;

    // Weight write qualifier: only in IDLE and only for in-range indices.
    always_comb begin
        w_ok = bus.w_we && (state == S_IDLE)
            && (int'(bus.w_class) < NUM_CLASSES)
            && (int'(bus.w_clause) < NUM_CLAUSES);
    end

    // Sign-extended weights of the clause currently being summed.
    always_comb begin
        for (int c = 0; c < NUM_CLASSES; c++) begin
            w_ext[c] = {{(SUM_W - WEIGHT_W){w_mem[c][idx][WEIGHT_W-1]}},
                        w_mem[c][idx]};
        end
    end

    // Control FSM, fired vector, result register and w_err pulse.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= S_IDLE;
            fired       <= '0;
            idx         <= '0;
            am_start    <= 1'b0;
            out_valid_q <= 1'b0;
            pred_q      <= '0;
            w_err_q     <= 1'b0;
        end else begin
            am_start <= 1'b0;
            w_err_q  <= bus.w_we && (state != S_IDLE);
            unique case (state)
                S_IDLE: begin
                    if (bus.frame_start) begin
                        fired <= bus.clause_valid ? bus.clause_op : '0;
                        state <= S_ACCUM;
                    end
                end
                S_ACCUM: begin
                    if (bus.clause_valid) begin
                        fired <= fired | bus.clause_op;
                    end
                    if (bus.frame_end) begin
                        idx   <= '0;
                        state <= S_SUM;
                    end
                end
                S_SUM: begin
                    idx <= idx + 1'b1;
                    if (idx == LAST_IDX) begin
`ifdef CLASS_SUM_CLAMP_EN
                        state <= S_CLAMP;
`else
                        state    <= S_ARGMAX;
                        am_start <= 1'b1;
`endif
                    end
                end
`ifdef CLASS_SUM_CLAMP_EN
                S_CLAMP: begin
                    state    <= S_ARGMAX;
                    am_start <= 1'b1;
                end
`endif
                S_ARGMAX: begin
                    if (am_done) begin
                        pred_q      <= am_pred;
                        out_valid_q <= 1'b1;
                        state       <= S_DONE;
                    end
                end
                S_DONE: begin
                    if (bus.out_ready) begin
                        out_valid_q <= 1'b0;
                        state       <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    // Weight table; reset wipes it so software must reload.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int c = 0; c < NUM_CLASSES; c++) begin
                for (int j = 0; j < NUM_CLAUSES; j++) begin
                    w_mem[c][j] <= '0;
                end
            end
        end else if (w_ok) begin
            w_mem[bus.w_class][bus.w_clause] <= bus.w_data;
        end
    end

    // Class sums: cleared at frame end, one clause per cycle in SUM.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int c = 0; c < NUM_CLASSES; c++) begin
                sum[c] <= '0;
            end
        end else if ((state == S_ACCUM) && bus.frame_end) begin
            for (int c = 0; c < NUM_CLASSES; c++) begin
                sum[c] <= '0;
            end
        end else if ((state == S_SUM) && fired[idx]) begin
            for (int c = 0; c < NUM_CLASSES; c++) begin
                sum[c] <= sum[c] + w_ext[c];
            end
`ifdef CLASS_SUM_CLAMP_EN
        end else if (state == S_CLAMP) begin
            for (int c = 0; c < NUM_CLASSES; c++) begin
                if (sum[c] > C_HI) begin
                    sum[c] <= C_HI;
                end else if (sum[c] < C_LO) begin
                    sum[c] <= C_LO;
                end
            end
`endif
        end
    end

    class_argmax_seq #(
        .NUM_CLASSES (NUM_CLASSES),
        .SUM_W       (SUM_W)
    ) u_argmax (
        .clk   (clk),
        .rst   (rst),
        .start (am_start),
        .sums  (sum),
        .done  (am_done),
        .pred  (am_pred)
    );

    for (genvar c = 0; c < NUM_CLASSES; c++) begin : g_pack
        assign bus.class_sums[c*SUM_W +: SUM_W] = sum[c];
    end

    assign bus.busy       = (state != S_IDLE);
    assign bus.out_valid  = out_valid_q;
    assign bus.pred_class = pred_q;
    assign bus.w_err      = w_err_q;

endmodule

// File: tb/tb_clause_vote_accumulator.sv
// tb_clause_vote_accumulator: randomized frames against a plain-arithmetic vote model.
// Honours CLASS_SUM_CLAMP_EN for expected sums and latency.
module tb_clause_vote_accumulator;
    import cotm_pkg::*;

    localparam int NCL   = NUM_CLAUSES_DEF;
    localparam int NCS   = NUM_CLASSES_DEF;
    localparam int WW    = WEIGHT_W_DEF;
    localparam int SW    = sum_width(WW, NCL);
    localparam int CLS_W = $clog2(NCS);
    localparam int CLA_W = $clog2(NCL);
`ifdef CLASS_SUM_CLAMP_EN
    localparam int LAT = NCL + NCS + 2;
`else
    localparam int LAT = NCL + NCS + 1;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    clause_vote_accumulator_if #(
        .NUM_CLAUSES (NCL),
        .NUM_CLASSES (NCS),
        .WEIGHT_W    (WW),
        .SUM_W       (SW)
    ) bus ();

    clause_vote_accumulator #(
        .NUM_CLAUSES (NCL),
        .NUM_CLASSES (NCS),
        .WEIGHT_W    (WW),
        .SUM_W       (SW)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int               wm [NCS][NCL];
    logic [NCL-1:0]   fr_op [8];
    bit               fr_v  [8];
    int               fr_n;
    int               exp_sum [NCS];
    int               exp_pred;
    logic [NCS*SW-1:0] exp_vec;
    int               checks   = 0;
    int               failures = 0;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.frame_start  = 1'b0;
        bus.clause_valid = 1'b0;
        bus.clause_op    = '0;
        bus.frame_end    = 1'b0;
        bus.w_we         = 1'b0;
        bus.w_class      = '0;
        bus.w_clause     = '0;
        bus.w_data       = '0;
        bus.out_ready    = 1'b0;
    endtask

    // Reference: OR the valid beats, add weights of fired clauses, pick max.
    function automatic void model();
        logic [NCL-1:0] f = '0;
        int s;
        for (int i = 0; i < fr_n; i++) begin
            if (fr_v[i]) f |= fr_op[i];
        end
        for (int c = 0; c < NCS; c++) begin
            s = 0;
            for (int j = 0; j < NCL; j++) begin
                if (f[j]) s += wm[c][j];
            end
`ifdef CLASS_SUM_CLAMP_EN
            if (s > CLAMP_T_DEF) s = CLAMP_T_DEF;
            if (s < -CLAMP_T_DEF) s = -CLAMP_T_DEF;
`endif
            exp_sum[c] = s;
        end
        exp_pred = 0;
        for (int c = 1; c < NCS; c++) begin
            if (exp_sum[c] > exp_sum[exp_pred]) exp_pred = c;
        end
        for (int c = 0; c < NCS; c++) begin
            exp_vec[c*SW +: SW] = SW'(exp_sum[c]);
        end
    endfunction

    task automatic write_w(input int c, input int j, input int d);
        bus.w_we     = 1'b1;
        bus.w_class  = CLS_W'(c);
        bus.w_clause = CLA_W'(j);
        bus.w_data   = WW'(d);
        tick();
        bus.w_we = 1'b0;
    endtask

    task automatic push_weights();
        for (int c = 0; c < NCS; c++) begin
            for (int j = 0; j < NCL; j++) begin
                write_w(c, j, wm[c][j]);
            end
        end
        for (int i = 0; i < 3; i++) begin
            write_w(int'($urandom_range(NCS, (1 << CLS_W) - 1)),
                    int'($urandom_range(0, NCL - 1)),
                    int'($urandom_range(0, 255)));
        end
        checks++;
        if (bus.w_err !== 1'b0) begin
            failures++;
            $display("FAIL w_err_idle: got %b want 0", bus.w_err);
        end
    endtask

    task automatic fill_weights(input int v);
        for (int c = 0; c < NCS; c++) begin
            for (int j = 0; j < NCL; j++) wm[c][j] = v;
        end
    endtask

    task automatic rand_weights();
        for (int c = 0; c < NCS; c++) begin
            for (int j = 0; j < NCL; j++) begin
                wm[c][j] = int'($urandom_range(0, 255)) - 128;
            end
        end
    endtask

    task automatic rand_frame();
        fr_n = int'($urandom_range(2, 8));
        for (int i = 0; i < 8; i++) begin
            fr_op[i] = NCL'($urandom);
            fr_v[i]  = ($urandom_range(0, 3) != 0);
        end
    endtask

    task automatic drive_frame();
        for (int i = 0; i < fr_n; i++) begin
            bus.frame_start  = (i == 0);
            bus.clause_valid = fr_v[i];
            bus.clause_op    = fr_op[i];
            bus.frame_end    = (i == fr_n - 1);
            tick();
        end
        bus.frame_start  = 1'b0;
        bus.clause_valid = 1'b0;
        bus.frame_end    = 1'b0;
        bus.clause_op    = NCL'($urandom);
    endtask

    task automatic wait_result(input int lat0, output int lat);
        lat = lat0;
        while (bus.out_valid !== 1'b1 && lat < LAT + 20) begin
            tick();
            lat++;
        end
    endtask

    task automatic check_out(input string name, input int lat);
        checks++;
        if (lat != LAT) begin
            failures++;
            $display("FAIL %s latency: got %0d want %0d", name, lat, LAT);
        end
        checks++;
        if (bus.pred_class !== CLS_W'(exp_pred)) begin
            failures++;
            $display("FAIL %s pred_class: got %0d want %0d",
                     name, bus.pred_class, exp_pred);
        end
        checks++;
        if (bus.class_sums !== exp_vec) begin
            failures++;
            $display("FAIL %s class_sums: got %h want %h",
                     name, bus.class_sums, exp_vec);
        end
    endtask

    task automatic accept(input string name);
        bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;
        checks++;
        if (bus.out_valid !== 1'b0 || bus.busy !== 1'b0) begin
            failures++;
            $display("FAIL %s accept: out_valid=%b busy=%b want 0 0",
                     name, bus.out_valid, bus.busy);
        end
    endtask

    task automatic run_and_check(input string name);
        int lat;
        model();
        drive_frame();
        wait_result(1, lat);
        check_out(name, lat);
        accept(name);
    endtask

    task automatic check_zero(input string name);
        checks++;
        if (bus.busy !== 1'b0 || bus.out_valid !== 1'b0 ||
            bus.pred_class !== '0 || bus.class_sums !== '0 ||
            bus.w_err !== 1'b0) begin
            failures++;
            $display("FAIL %s: busy=%b ov=%b pred=%0d sums=%h werr=%b want all 0",
                     name, bus.busy, bus.out_valid, bus.pred_class,
                     bus.class_sums, bus.w_err);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        check_zero("reset");
        rst = 1'b0;
        tick();
        check_zero("post_reset");
    endtask

    task automatic test_basic();
        fill_weights(1);
        for (int j = 0; j < NCL; j++) wm[3][j] = 5;
        push_weights();
        fr_n = 3;
        fr_op[0] = NCL'(16'h0001); fr_v[0] = 1'b1;
        fr_op[1] = NCL'(16'h0002); fr_v[1] = 1'b1;
        fr_op[2] = NCL'(16'h0005); fr_v[2] = 1'b1;
        run_and_check("basic");
        checks++;
        if (bus.class_sums[3*SW +: SW] !== SW'(15) || bus.pred_class !== CLS_W'(3)) begin
            failures++;
            $display("FAIL basic_const: sum3=%0d pred=%0d want 15 3",
                     bus.class_sums[3*SW +: SW], bus.pred_class);
        end
    endtask

    task automatic test_ties();
        fill_weights(1);
        wm[2][0] = 5; wm[2][1] = 5;
        wm[7][0] = 5; wm[7][1] = 5;
        push_weights();
        fr_n = 2;
        fr_op[0] = NCL'(16'h0003); fr_v[0] = 1'b1;
        fr_op[1] = NCL'(16'hFFFF); fr_v[1] = 1'b0;
        run_and_check("ties");
        checks++;
        if (bus.pred_class !== CLS_W'(2)) begin
            failures++;
            $display("FAIL ties_const: pred got %0d want 2", bus.pred_class);
        end
    endtask

    task automatic test_empty();
        fr_n = 2;
        fr_op[0] = NCL'($urandom); fr_v[0] = 1'b0;
        fr_op[1] = NCL'($urandom); fr_v[1] = 1'b0;
        run_and_check("empty");
    endtask

    task automatic test_w_err();
        int lat;
        rand_weights();
        push_weights();
        rand_frame();
        fr_op[0][0] = 1'b1;
        fr_v[0]     = 1'b1;
        model();
        drive_frame();
        bus.w_we     = 1'b1;
        bus.w_class  = CLS_W'(3);
        bus.w_clause = '0;
        bus.w_data   = ~WW'(wm[3][0]);
        tick();
        bus.w_we = 1'b0;
        checks++;
        if (bus.w_err !== 1'b1) begin
            failures++;
            $display("FAIL w_err_pulse: got %b want 1", bus.w_err);
        end
        tick();
        checks++;
        if (bus.w_err !== 1'b0) begin
            failures++;
            $display("FAIL w_err_clear: got %b want 0", bus.w_err);
        end
        wait_result(3, lat);
        check_out("w_err_run", lat);
        accept("w_err_run");
        run_and_check("w_err_rerun");
    endtask

    task automatic test_backpressure();
        int lat;
        rand_frame();
        model();
        drive_frame();
        wait_result(1, lat);
        check_out("bp", lat);
        for (int i = 0; i < 5; i++) begin
            if (i == 2) begin
                bus.frame_start  = 1'b1;
                bus.clause_valid = 1'b1;
                bus.clause_op    = '1;
            end
            tick();
            bus.frame_start  = 1'b0;
            bus.clause_valid = 1'b0;
            checks++;
            if (bus.out_valid !== 1'b1 || bus.pred_class !== CLS_W'(exp_pred) ||
                bus.class_sums !== exp_vec) begin
                failures++;
                $display("FAIL bp_hold%0d: ov=%b pred=%0d sums=%h want 1 %0d %h",
                         i, bus.out_valid, bus.pred_class, bus.class_sums,
                         exp_pred, exp_vec);
            end
        end
        accept("bp");
    endtask

    task automatic test_clamp();
        fill_weights(1);
        for (int j = 0; j < NCL; j++) wm[1][j] = 100;
        push_weights();
        fr_n = 2;
        fr_op[0] = NCL'(16'h0010); fr_v[0] = 1'b1;
        fr_op[1] = NCL'(16'h0200); fr_v[1] = 1'b1;
        run_and_check("clamp");
        checks++;
`ifdef CLASS_SUM_CLAMP_EN
        if (bus.class_sums[1*SW +: SW] !== SW'(64)) begin
            failures++;
            $display("FAIL clamp_const: sum1 got %0d want 64",
                     bus.class_sums[1*SW +: SW]);
        end
`else
        if (bus.class_sums[1*SW +: SW] !== SW'(200)) begin
            failures++;
            $display("FAIL clamp_const: sum1 got %0d want 200",
                     bus.class_sums[1*SW +: SW]);
        end
`endif
    endtask

    task automatic test_random();
        for (int r = 0; r < 4; r++) begin
            rand_weights();
            push_weights();
            for (int f = 0; f < 2; f++) begin
                rand_frame();
                run_and_check("random");
            end
        end
    endtask

    task automatic test_reset_mid_sum();
        fill_weights(3);
        for (int j = 0; j < NCL; j++) wm[5][j] = 9;
        push_weights();
        fr_n = 2;
        fr_op[0] = NCL'(16'h000F); fr_v[0] = 1'b1;
        fr_op[1] = NCL'(16'h00F0); fr_v[1] = 1'b1;
        run_and_check("pre_reset");
        drive_frame();
        tick();
        tick();
        tick();
        rst = 1'b1;
        #1;
        check_zero("reset_async");
        tick();
        check_zero("reset_mid_sum");
        rst = 1'b0;
        tick();
        fill_weights(0);
        fr_n = 2;
        fr_op[0] = '1; fr_v[0] = 1'b1;
        fr_op[1] = '1; fr_v[1] = 1'b1;
        run_and_check("weights_cleared");
    endtask

    initial begin
        idle_inputs();
        test_reset();
        test_basic();
        test_ties();
        test_empty();
        test_w_err();
        test_backpressure();
        test_clamp();
        test_random();
        test_reset_mid_sum();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/clause_vote_accumulator.md
Name: clause_vote_accumulator

Overview:
- Sits directly downstream of the per-clause convolution units in the CoTM datapath.
- Consumes one clause_op bit per clause for each patch position of an image frame.
- ORs each clause's output across all positions, then computes signed weighted class sums, one clause per cycle.
- Selects the predicted class by sequential argmax and returns it over a valid/ready handshake.

Parameters:
- NUM_CLAUSES, 16, number of clause units feeding the block.
- NUM_CLASSES, 10, number of output classes.
- WEIGHT_W, 8, signed clause-weight width.
- SUM_W, WEIGHT_W+$clog2(NUM_CLAUSES)+1, signed class-sum width.
- CLAMP_T, 64, class-sum clamp threshold (used only with the optional feature).

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- frame_start  in  1  first patch position of a new image
- clause_valid  in  1  clause_op is valid this cycle (one cycle per patch position)
- clause_op  in  NUM_CLAUSES  per-clause match at current position
- frame_end  in  1  last patch position of the image
- w_we  in  1  weight write strobe
- w_class  in  $clog2(NUM_CLASSES)  weight write class index
- w_clause  in  $clog2(NUM_CLAUSES)  weight write clause index
- w_data  in  WEIGHT_W  signed weight value
- w_err  out  1  one-cycle pulse: write dropped because block not IDLE
- busy  out  1  state != IDLE
- out_valid  out  1  prediction available
- out_ready  in  1  consumer accepts prediction
- pred_class  out  $clog2(NUM_CLASSES)  argmax class
- class_sums  out  NUM_CLASSES*SUM_W  packed signed sums, class 0 in LSBs

Behaviour:
- Reset (async) clears all of the following to 0: state=IDLE, fired vector, sums, weight registers, out_valid, pred_class, w_err, busy.
- States: IDLE, ACCUM, SUM, ARGMAX, DONE.
- IDLE:
  - frame_start -> clear fired; go to ACCUM.
  - A clause_valid in the same cycle as frame_start is ORed in.
  - Weight writes are accepted only in IDLE: W[w_class][w_clause] <= w_data.
  - Out-of-range indices are ignored.
- ACCUM:
  - On clause_valid: fired <= fired | clause_op.
  - frame_end (with or without clause_valid in the same cycle; a valid beat is included) -> go to SUM with idx=0 and all sums cleared.
  - frame_start while in ACCUM is ignored.
- SUM:
  - Runs for NUM_CLAUSES cycles.
  - Each cycle, if fired[idx], then sum[c] += W[c][idx] for every class c in parallel.
  - Additions are full-width signed; SUM_W cannot overflow.
  - After idx=NUM_CLAUSES-1, go to ARGMAX.
- ARGMAX:
  - Runs for NUM_CLASSES cycles. Cycle k compares sum[k] with best; k=0 loads best.
  - Strict greater-than, so ties resolve to the lowest class index.
- DONE:
  - out_valid=1; pred_class and class_sums stable.
  - On out_ready, go to IDLE and drop out_valid the next cycle.
  - If out_ready is already high on entry, DONE lasts exactly 1 cycle.
- Latency: frame_end in cycle t -> out_valid high in cycle t+NUM_CLAUSES+NUM_CLASSES+1 (27 with defaults).
- A frame with no clause_valid beats gives fired=0, all sums 0, pred_class 0.
- w_we outside IDLE: write dropped; w_err pulses for 1 cycle.
- Inputs other than out_ready and weight writes are ignored in SUM/ARGMAX/DONE.
- Reset mid-operation aborts immediately and clears weights; software must reload them.

Optional Feature:
- Macro CLASS_SUM_CLAMP_EN.
- When defined: after SUM completes, each sum is saturated to [-CLAMP_T, +CLAMP_T] in one extra cycle before ARGMAX. Latency becomes +1 (28 with defaults). class_sums reports the clamped values.
- When undefined: no clamp stage, raw sums are used, and CLAMP_T is unused.

Decomposition:
- Shared package cotm_pkg holds:
  - state enum (IDLE/ACCUM/SUM/ARGMAX/DONE);
  - default NUM_CLAUSES/NUM_CLASSES/WEIGHT_W constants;
  - SUM_W derivation function.
- One sub-module, class_argmax_seq: sequential argmax over the sum array with start/done and lowest-index tie-break.

Test Plan:
- Weights all +1, frame of 3 beats firing clauses {0}, {1}, {0,2}; W[3][*]=+5 -> out_valid at frame_end+27, pred_class=3, class_sums[3]=15, others 3.
- Ties: classes 2 and 7 both sum 10 -> pred_class=2.
- Frame with frame_start then frame_end and no clause_valid -> all sums 0, pred_class=0.
- w_we asserted during SUM -> w_err pulses once, weight unchanged; a later rerun gives an identical prediction.
- out_ready held low for 5 cycles in DONE -> out_valid and outputs stable; new frame_start ignored until acceptance.
- With CLASS_SUM_CLAMP_EN, W[1][*]=+100 and 2 clauses fired -> class_sums[1]=64, latency 28; rst asserted mid-SUM -> all outputs 0 the next cycle.
